// File: rtl/dcsformer_pkg.sv
// dcsformer_pkg
// Shared constants and types for the DCSformer host driver.
//   N_ROWS / N_COLS : activation geometry (8 x 16 bytes, streamed row-major)
//   DW / OW         : byte width of activation/weight beats, result word width
//   N_ACT / N_WGT   : beat counts of the activation and weight bursts
//   TMO             : cycles allowed in a wait state before the job errors out
//   GAP             : idle cycles required after a job before a new start
//   state_t         : FSM state encoding (constants S_*)
//   result_t        : one captured result word
package dcsformer_pkg;

    localparam int N_ROWS  = 8;
    localparam int N_COLS  = 16;
    localparam int DW      = 8;
    localparam int OW      = 32;
    localparam int N_ACT   = N_ROWS * N_COLS;
    localparam int N_WGT   = 8;
    localparam int TMO     = 1023;
    localparam int GAP     = 2;

    localparam int BEAT_W  = 7;
    localparam int WBEAT_W = 3;
    localparam int IDX_W   = 4;
    localparam int TMO_W   = 10;
    localparam int GAP_W   = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_SEND_I  = 3'd1;
    localparam state_t S_WAIT_WR = 3'd2;
    localparam state_t S_SEND_W  = 3'd3;
    localparam state_t S_WAIT_O  = 3'd4;
    localparam state_t S_RECV    = 3'd5;
    localparam state_t S_DONE    = 3'd6;

    typedef logic [OW-1:0] result_t;

endpackage

// File: rtl/dcsformer_beat_ctr.sv
// dcsformer_beat_ctr
// Up-counter with synchronous load, count enable and terminal-count flag.
//   clk, rst : clock and asynchronous active-high reset (count -> 0)
//   load     : load load_val this cycle (has priority over en)
//   load_val : value to load
//   en       : increment this cycle
//   count    : current value
//   tc       : high while count equals TERM
module dcsformer_beat_ctr #(
    parameter int          W    = 7,
    parameter int unsigned TERM = 127
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    // Load wins over enable so that the owning FSM can hold the counter
    // at its start value simply by keeping load asserted outside its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(TERM));

endmodule

// File: rtl/dcsformer_host_driver.sv
// dcsformer_host_driver
// Host-side transmitter/collector for the DCSformer accelerator. The host
// preloads a 128-byte activation buffer and an 8-byte weight buffer; on start
// the block streams activations, waits for w_ready, streams weights, then
// captures eight result words.
//   clk, rst             : clock, asynchronous active-high reset
//   ld_en/ld_sel/ld_addr/ld_data : host buffer writes (only honoured in IDLE)
//   start                : single-cycle job request
//   busy/done/err        : job status (err is sticky until next accepted start)
//   rd_addr/rd_data      : combinational result read port
//   i_valid/i_data       : activation stream to accelerator
//   w_ready              : accelerator pulse, ready for weights
//   w_valid/w_data       : weight stream to accelerator
//   o_valid/o_data       : result stream from accelerator
module dcsformer_host_driver
    import dcsformer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic          ld_sel,
    input  logic [6:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [2:0]    rd_addr,
    output logic [OW-1:0] rd_data,
    output logic          i_valid,
    output logic [DW-1:0] i_data,
    input  logic          w_ready,
    output logic          w_valid,
    output logic [DW-1:0] w_data,
    input  logic          o_valid,
    input  logic [OW-1:0] o_data
);

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;

    logic [DW-1:0]      act_buf [N_ACT];
    logic [DW-1:0]      w_buf   [N_WGT];
    result_t            result  [N_ROWS];

    logic [BEAT_W-1:0]  act_cnt;
    logic               act_tc;
    logic [WBEAT_W-1:0] w_cnt;
    logic               w_tc;
    logic [IDX_W-1:0]   res_cnt;
    logic               res_tc;
    logic [TMO_W-1:0]   tmo_cnt_unused;
    logic               tmo_tc;

    logic               start_ok;
    logic               in_send_i;
    logic               in_send_w;
    logic               waiting;
    logic               collecting;
    logic               capture;

    assign in_send_i  = (state == S_SEND_I);
    assign in_send_w  = (state == S_SEND_W);
    assign waiting    = (state == S_WAIT_WR) || (state == S_WAIT_O);
    assign collecting = (state == S_WAIT_O) || (state == S_RECV);
    assign start_ok   = (state == S_IDLE) && start && (gap_cnt == '0);

    // Bit 3 of the result index only becomes set after the eighth word,
    // so it doubles as a guard against writing past the result array.
    assign capture    = collecting && o_valid && !res_cnt[IDX_W-1];

    // Each counter is parked at zero outside the state that uses it, so every
    // burst and every wait window starts counting from zero on entry.
    dcsformer_beat_ctr #(.W(BEAT_W), .TERM(N_ACT - 1)) u_act_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (!in_send_i),
        .load_val ('0),
        .en       (in_send_i),
        .count    (act_cnt),
        .tc       (act_tc)
    );

    dcsformer_beat_ctr #(.W(WBEAT_W), .TERM(N_WGT - 1)) u_w_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (!in_send_w),
        .load_val ('0),
        .en       (in_send_w),
        .count    (w_cnt),
        .tc       (w_tc)
    );

    dcsformer_beat_ctr #(.W(IDX_W), .TERM(N_ROWS - 1)) u_res_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (!collecting),
        .load_val ('0),
        .en       (capture),
        .count    (res_cnt),
        .tc       (res_tc)
    );

    // Terminal value is TMO-1 so that the state after a silent wait window
    // of exactly TMO cycles is DONE; only the terminal flag is consumed.
    dcsformer_beat_ctr #(.W(TMO_W), .TERM(TMO - 1)) u_tmo_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (!waiting),
        .load_val ('0),
        .en       (waiting),
        .count    (tmo_cnt_unused),
        .tc       (tmo_tc)
    );

    // Job sequencer. A handshake seen in the same cycle as the timeout
    // terminal count wins, so a late-but-valid accelerator is not failed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            err     <= 1'b0;
            gap_cnt <= GAP_W'(GAP);
        end else begin
            case (state)
                S_IDLE: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                    if (start_ok) begin
                        err   <= 1'b0;
                        state <= S_SEND_I;
                    end
                end
                S_SEND_I: begin
                    if (act_tc) begin
                        state <= S_WAIT_WR;
                    end
                end
                S_WAIT_WR: begin
                    if (w_ready) begin
                        state <= S_SEND_W;
                    end else if (tmo_tc) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_SEND_W: begin
                    if (w_tc) begin
                        state <= S_WAIT_O;
                    end
                end
                S_WAIT_O: begin
                    if (o_valid) begin
                        state <= S_RECV;
                    end else if (tmo_tc) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_RECV: begin
                    if (o_valid && res_tc) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    gap_cnt <= GAP_W'(GAP);
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Host buffer writes are accepted only while idle so a running job
    // always streams the contents it started with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ACT; i++) begin
                act_buf[i] <= '0;
            end
            for (int j = 0; j < N_WGT; j++) begin
                w_buf[j] <= '0;
            end
        end else if (ld_en && (state == S_IDLE)) begin
            if (!ld_sel) begin
                act_buf[ld_addr] <= ld_data;
            end else begin
                w_buf[ld_addr[WBEAT_W-1:0]] <= ld_data;
            end
        end
    end

    // The first beat is taken in WAIT_O where the index is still zero,
    // so result[0] lands in the same cycle that moves the FSM to RECV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_ROWS; n++) begin
                result[n] <= '0;
            end
        end else if (capture) begin
            result[res_cnt[2:0]] <= o_data;
        end
    end

    // Stream outputs are decoded from state so they fall to zero the
    // instant reset is applied.
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign i_valid = in_send_i;
    assign i_data  = in_send_i ? act_buf[act_cnt] : '0;
    assign w_valid = in_send_w;
    assign w_data  = in_send_w ? w_buf[w_cnt] : '0;
    assign rd_data = result[rd_addr];

endmodule

// File: doc/dcsformer_host_driver.md
Name: dcsformer_host_driver

Overview:
- Host-side transmitter/collector for the DCSformer accelerator.
- A host preloads a 128-byte activation buffer (8 rows x 16 cols) and an 8-byte weight buffer. On start, the block streams activations on i_valid/i_data, waits for the w_ready pulse, streams weights on w_valid/w_data, then captures the eight 32-bit results returned on o_valid/o_data.
- Sits between the system host/testbench and the accelerator.

Parameters:
- N_ROWS, 8, activation rows and number of result words.
- N_COLS, 16, bytes per activation row (N_ROWS*N_COLS = 128 stream beats).
- DW, 8, activation/weight byte width.
- OW, 32, result word width.
- TMO, 1023, max wait cycles in WAIT_WR or WAIT_O before error.
- GAP, 2, min idle cycles after a job before the next start is accepted.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_en  in  1  host buffer write strobe.
- ld_sel  in  1  0 = activation buffer, 1 = weight buffer.
- ld_addr  in  7  byte address (weight buffer uses bits [2:0]).
- ld_data  in  DW  write data.
- start  in  1  single-cycle job request.
- busy  out  1  high from start acceptance until DONE exit.
- done  out  1  one-cycle pulse when all 8 results are captured.
- err  out  1  sticky timeout flag; cleared by next accepted start.
- rd_addr  in  3  result index.
- rd_data  out  OW  result[rd_addr], combinational read.
- i_valid  out  1  activation beat valid.
- i_data  out  DW  activation byte.
- w_ready  in  1  accelerator pulse: ready for weights.
- w_valid  out  1  weight beat valid.
- w_data  out  DW  weight byte.
- o_valid  in  1  result beat valid.
- o_data  in  OW  result word.

Behaviour:
- Reset values: busy=0, done=0, err=0, i_valid=0, w_valid=0, i_data=0, w_data=0, state=IDLE, gap counter=GAP. Results and buffers are cleared to 0.
- FSM states: IDLE, SEND_I, WAIT_WR, SEND_W, WAIT_O, RECV, DONE.
- IDLE:
  - start is accepted only when the gap counter is 0.
  - On acceptance: err cleared, beat counter=0, go to SEND_I. busy rises the cycle after the start is sampled.
- SEND_I:
  - i_valid=1 for exactly 128 consecutive cycles, starting the cycle after acceptance.
  - i_data = act_buf[k], k=0..127, row-major (row = k/16).
  - After the beat k=127, go to WAIT_WR. i_valid=0 the next cycle.
- WAIT_WR:
  - Timeout counter counts cycles.
  - On w_ready=1, go to SEND_W. w_valid rises on the next cycle.
  - If the counter reaches TMO: err=1, go to DONE.
  - w_ready seen in any other state is ignored.
- SEND_W: w_valid=1 for exactly 8 consecutive cycles, w_data = w_buf[j], j=0..7. Then go to WAIT_O.
- WAIT_O:
  - Timeout counter counts cycles.
  - The first o_valid=1 cycle moves to RECV and is captured as result[0] in that same cycle.
  - If the counter reaches TMO: err=1, go to DONE.
- RECV:
  - Each o_valid=1 cycle stores o_data into result[n], then n++. Beats need not be contiguous.
  - When n reaches 8, go to DONE. Extra beats are ignored.
  - o_valid outside WAIT_O/RECV is ignored.
- DONE: done=1 for one cycle, busy=0 next, gap counter loaded with GAP, return to IDLE. The gap counter decrements to 0 in IDLE.
- Latency: start to first i_valid is 1 cycle. The block adds no wait states inside the bursts.
- Host loads: ld_en is honoured only in IDLE. Writes while busy are dropped.
- rd_data: live reads are allowed at any time. During RECV the word at the current index may update.
- start while busy: ignored and not queued.
- Reset mid-job: all outputs drop immediately (async) to their reset values. The accelerator must be reset together with this block.
- Widths: beat counter 7 bits, result index 4 bits (detects 8), timeout counter 10 bits.

Decomposition:
- Shared package dcsformer_pkg holds:
  - the constants N_ROWS, N_COLS, DW, OW and the beat counts 128 and 8;
  - a typedef for the FSM state enum;
  - a typedef for the result word.
- One natural sub-module: dcsformer_beat_ctr, a load/enable/terminal-count counter. It is instantiated for the activation beats, weight beats, result beats and the timeout.

Test Plan:
- Load act_buf[k] = k+1, w_buf = 1..8, start → i_valid high for 128 cycles with i_data = 1..128, then w_valid for 8 cycles with 1..8 one cycle after w_ready.
- Accelerator model returns results 100..107 on 8 contiguous o_valid beats → rd_data[0..7] = 100..107, single done pulse, err=0.
- Same job but results arrive with 1-cycle bubbles between beats → all 8 captured correctly, done only after the 8th beat.
- w_ready never asserted → err=1 and done pulse exactly 1023 cycles after entering WAIT_WR; i_valid and w_valid stay 0; the next start clears err.
- start pulsed and ld_en writes during SEND_I, plus start 1 cycle after done → all ignored, buffers unchanged; start accepted at ≥2 idle cycles.
- rst asserted at i_valid beat 50 → i_valid=0 and busy=0 asynchronously, buffers and results zeroed; a fresh load and start completes normally.
